// File: rtl/game_phase_sequencer_pkg.sv
// Shared types and constants for the bomb-round phase sequencer.
package game_pkg;

    localparam int unsigned PHASE_W = 3;
    localparam int unsigned LFSR_W  = 5;

    typedef enum logic [PHASE_W-1:0] {
        IDLE  = 3'd0,
        ARM   = 3'd1,
        SHOW  = 3'd2,
        INPUT = 3'd3,
        WIN   = 3'd4,
        LOSE  = 3'd5
    } phase_e;

    // x^5 + x^3 + 1: feedback from bits 4 and 2 of a left-shifting register
    localparam logic [LFSR_W-1:0] LFSR_TAPS = 5'b10100;
    localparam logic [LFSR_W-1:0] LFSR_SEED = 5'b00001;

endpackage

// File: rtl/sec_tick_gen.sv
// One-second time base; clr restarts the count so the first tick lands TICK_DIV cycles later.
module sec_tick_gen #(
    parameter int unsigned TICK_DIV = 1000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    output logic tick
);

    localparam int unsigned CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        tick  = (cnt_q == CNT_LAST);
        cnt_d = (clr || tick) ? '0 : cnt_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/game_phase_sequencer.sv
// Phase FSM for one bomb round: arm, code show, input window, win/lose hold, auto-restart.
module game_phase_sequencer
    import game_pkg::*;
#(
    parameter int unsigned TICK_DIV   = 1000,
    parameter int unsigned SHOW_SEC   = 5,
    parameter int unsigned INPUT_SEC  = 20,
    parameter int unsigned RESULT_SEC = 3,
    parameter int unsigned CODE_W     = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              sw_en,
    input  logic              btn_start,
    input  logic              code_ok,
    input  logic              code_bad,
    output logic              mod_rst_n,
    output logic              bomb_on,
    output logic              show_on,
    output logic              input_en,
    output logic              cd_on,
    output logic [4:0]        sec_left,
    output logic [CODE_W-1:0] code,
    output logic              win,
    output logic              lose,
    output logic [PHASE_W-1:0] phase
);

    if (SHOW_SEC < 1 || SHOW_SEC > 31 || INPUT_SEC < 1 || INPUT_SEC > 31 ||
        RESULT_SEC < 1 || RESULT_SEC > 31 || CODE_W < 1 || TICK_DIV < 1) begin : g_bad_param
        $error("game_phase_sequencer: parameter out of range");
    end

    localparam logic [4:0] SHOW_S   = 5'(SHOW_SEC);
    localparam logic [4:0] INPUT_S  = 5'(INPUT_SEC);
    localparam logic [4:0] RES_LAST = 5'(RESULT_SEC - 1);

    phase_e              state_q, state_d;
    logic [LFSR_W-1:0]   lfsr_q, lfsr_d;
    logic [CODE_W-1:0]   code_q, code_d;
    logic [4:0]          sec_q, sec_d;
    logic [4:0]          res_q, res_d;
    logic                btn_q;
    logic                mod_rst_n_q, mod_rst_n_d;
    logic                bomb_q, bomb_d, show_q, show_d, inen_q, inen_d, cd_q, cd_d;
    logic                win_q, win_d, lose_q, lose_d;
    logic                start, entering, tick;

    sec_tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (entering),
        .tick  (tick)
    );

    always_comb begin
        start   = btn_start & ~btn_q;
        state_d = state_q;
        if (state_q != IDLE && !sw_en) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:  if (sw_en && start) state_d = ARM;
                ARM:   state_d = SHOW;
                SHOW:  if (tick && sec_q == 5'd1) state_d = INPUT;
                INPUT: begin
                    if (code_ok)                      state_d = WIN;
                    else if (code_bad)                state_d = LOSE;
                    else if (tick && sec_q == 5'd1)   state_d = LOSE;
                end
                WIN, LOSE: if (tick && res_q == RES_LAST) state_d = ARM;
                default: state_d = IDLE;
            endcase
        end
        entering = (state_d != state_q);

        lfsr_d = {lfsr_q[LFSR_W-2:0], ^(lfsr_q & LFSR_TAPS)};

        // Code is latched once per round, on the edge that enters ARM
        code_d = code_q;
        if (state_d == ARM && entering) begin
            code_d = (lfsr_q == '0) ? CODE_W'(LFSR_SEED) : CODE_W'(lfsr_q);
        end

        // WIN/LOSE keep whatever sec_left held on the edge that left INPUT
        sec_d = sec_q;
        case (state_d)
            IDLE, ARM: sec_d = '0;
            SHOW:      sec_d = entering ? SHOW_S  : (tick ? sec_q - 5'd1 : sec_q);
            INPUT:     sec_d = entering ? INPUT_S : (tick ? sec_q - 5'd1 : sec_q);
            default:   sec_d = sec_q;
        endcase

        res_d = entering ? 5'd0 : (tick ? res_q + 5'd1 : res_q);

        mod_rst_n_d = !((state_d == ARM) || (state_d == IDLE && state_q != IDLE));
        bomb_d      = (state_d == SHOW) || (state_d == INPUT);
        show_d      = (state_d == SHOW);
        inen_d      = (state_d == INPUT);
        cd_d        = (state_d == INPUT);
        win_d       = (state_d == WIN);
        lose_d      = (state_d == LOSE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            lfsr_q      <= LFSR_SEED;
            code_q      <= '0;
            sec_q       <= '0;
            res_q       <= '0;
            btn_q       <= 1'b0;
            mod_rst_n_q <= 1'b1;
            bomb_q      <= 1'b0;
            show_q      <= 1'b0;
            inen_q      <= 1'b0;
            cd_q        <= 1'b0;
            win_q       <= 1'b0;
            lose_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            lfsr_q      <= lfsr_d;
            code_q      <= code_d;
            sec_q       <= sec_d;
            res_q       <= res_d;
            btn_q       <= btn_start;
            mod_rst_n_q <= mod_rst_n_d;
            bomb_q      <= bomb_d;
            show_q      <= show_d;
            inen_q      <= inen_d;
            cd_q        <= cd_d;
            win_q       <= win_d;
            lose_q      <= lose_d;
        end
    end

    assign mod_rst_n = mod_rst_n_q;
    assign bomb_on   = bomb_q;
    assign show_on   = show_q;
    assign input_en  = inen_q;
    assign cd_on     = cd_q;
    assign sec_left  = sec_q;
    assign code      = code_q;
    assign win       = win_q;
    assign lose      = lose_q;
    assign phase     = state_q;

endmodule

// File: tb/tb_game_phase_sequencer.sv
// Directed scenarios followed by random traffic, checked against a time-based phase model.
module tb_game_phase_sequencer;

    localparam int TD = 4;
    localparam int SS = 5;
    localparam int IS = 20;
    localparam int RS = 3;
    localparam int P_IDLE = 0, P_ARM = 1, P_SHOW = 2, P_INPUT = 3, P_WIN = 4, P_LOSE = 5;

    logic       clk = 1'b0;
    logic       rst_n, sw_en, btn_start, code_ok, code_bad;
    logic       mod_rst_n, bomb_on, show_on, input_en, cd_on, win, lose;
    logic [4:0] sec_left, code;
    logic [2:0] phase;

    game_phase_sequencer #(
        .TICK_DIV   (TD),
        .SHOW_SEC   (SS),
        .INPUT_SEC  (IS),
        .RESULT_SEC (RS),
        .CODE_W     (5)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .sw_en     (sw_en),
        .btn_start (btn_start),
        .code_ok   (code_ok),
        .code_bad  (code_bad),
        .mod_rst_n (mod_rst_n),
        .bomb_on   (bomb_on),
        .show_on   (show_on),
        .input_en  (input_en),
        .cd_on     (cd_on),
        .sec_left  (sec_left),
        .code      (code),
        .win       (win),
        .lose      (lose),
        .phase     (phase)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // Model: phase plus cycles spent in it; sec_left is derived from elapsed time
    int         m_ph, m_t, m_frozen, m_age;
    logic [4:0] m_code;
    logic       m_prev, m_mrst;
    logic [4:0] lseq[31];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_edge();
        int  nph;
        bit  start;
        if (!rst_n) begin
            m_ph = P_IDLE; m_t = 0; m_code = '0; m_age = 0; m_prev = 1'b0;
            m_mrst = 1'b1; m_frozen = 0;
        end else begin
            start = btn_start && !m_prev;
            nph = m_ph;
            if (m_ph != P_IDLE && !sw_en) nph = P_IDLE;
            else begin
                case (m_ph)
                    P_IDLE:  if (sw_en && start) nph = P_ARM;
                    P_ARM:   nph = P_SHOW;
                    P_SHOW:  if (m_t == SS * TD - 1) nph = P_INPUT;
                    P_INPUT: begin
                        if (code_ok)                  nph = P_WIN;
                        else if (code_bad)            nph = P_LOSE;
                        else if (m_t == IS * TD - 1)  nph = P_LOSE;
                    end
                    default: if (m_t == RS * TD - 1) nph = P_ARM;
                endcase
            end
            if (m_ph == P_INPUT && nph != P_INPUT) m_frozen = IS - m_t / TD;
            if (nph == P_ARM) m_code = lseq[m_age % 31];
            m_mrst = !(nph == P_ARM || (nph == P_IDLE && m_ph != P_IDLE));
            m_t    = (nph != m_ph) ? 0 : m_t + 1;
            m_prev = btn_start;
            m_age++;
            m_ph   = nph;
        end
    endtask

    task automatic check_all();
        int sl;
        if (m_ph == P_SHOW)                       sl = SS - m_t / TD;
        else if (m_ph == P_INPUT)                 sl = IS - m_t / TD;
        else if (m_ph == P_WIN || m_ph == P_LOSE) sl = m_frozen;
        else                                      sl = 0;
        check("phase",     phase,     m_ph);
        check("mod_rst_n", mod_rst_n, m_mrst);
        check("bomb_on",   bomb_on,   m_ph == P_SHOW || m_ph == P_INPUT);
        check("show_on",   show_on,   m_ph == P_SHOW);
        check("input_en",  input_en,  m_ph == P_INPUT);
        check("cd_on",     cd_on,     m_ph == P_INPUT);
        check("win",       win,       m_ph == P_WIN);
        check("lose",      lose,      m_ph == P_LOSE);
        check("sec_left",  sec_left,  sl);
        check("code",      code,      m_code);
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic run_until(input int ph, input int limit);
        int n = 0;
        while (m_ph != ph && n < limit) begin
            step();
            n++;
        end
        check("reach_phase", phase, ph);
    endtask

    logic [4:0] prev_code;

    initial begin
        lseq[0] = 5'b00001;
        for (int k = 1; k < 31; k++) begin
            lseq[k] = {lseq[k-1][3:0], lseq[k-1][4] ^ lseq[k-1][2]};
        end
        rst_n = 1'b0; sw_en = 1'b0; btn_start = 1'b0; code_ok = 1'b0; code_bad = 1'b0;
        steps(2);
        check("rst_phase", phase, 0);
        check("rst_mod_rst_n", mod_rst_n, 1);

        // 1: start edge at cycle 10, ARM one cycle, SHOW 20 clk, INPUT at 20 s
        rst_n = 1'b1; sw_en = 1'b1;
        steps(9);
        btn_start = 1'b1;
        step();
        check("t1_arm", phase, 1);
        check("t1_mod_rst_pulse", mod_rst_n, 0);
        btn_start = 1'b0;
        step();
        check("t1_show", phase, 2);
        check("t1_show_sec", sec_left, 5);
        steps(19);
        check("t1_show_last", phase, 2);
        step();
        check("t1_input", phase, 3);
        check("t1_input_sec", sec_left, 20);

        // 2: code_ok on 8th INPUT cycle -> WIN, ARM 12 clk later with a new code
        steps(7);
        code_ok = 1'b1;
        step();
        code_ok = 1'b0;
        check("t2_win", win, 1);
        check("t2_input_off", input_en, 0);
        prev_code = code;
        steps(11);
        check("t2_hold", phase, 4);
        step();
        check("t2_rearm", phase, 1);
        vectors++;
        assert (code !== prev_code) else begin
            miscompares++;
            $error("FAIL t2_new_code: observed %0h expected not %0h", code, prev_code);
        end

        // 3: timeout -> LOSE exactly 80 clk after INPUT entry
        run_until(P_INPUT, 40);
        steps(79);
        check("t3_last_input", phase, 3);
        check("t3_last_sec", sec_left, 1);
        step();
        check("t3_lose", lose, 1);

        // 4: pulses in SHOW ignored; ok+bad together -> WIN; bad alone -> LOSE
        run_until(P_SHOW, 20);
        code_ok = 1'b1; code_bad = 1'b1;
        step();
        code_ok = 1'b0; code_bad = 1'b0;
        check("t4_show_ignores", phase, 2);
        run_until(P_INPUT, 40);
        code_ok = 1'b1; code_bad = 1'b1;
        step();
        code_ok = 1'b0; code_bad = 1'b0;
        check("t4_ok_wins", phase, 4);
        run_until(P_INPUT, 60);
        code_bad = 1'b1;
        step();
        code_bad = 1'b0;
        check("t4_bad_loses", phase, 5);

        // 5: sw_en drop mid-INPUT; held button must not restart
        run_until(P_INPUT, 60);
        steps(5);
        sw_en = 1'b0;
        step();
        check("t5_idle", phase, 0);
        check("t5_mod_rst_pulse", mod_rst_n, 0);
        check("t5_bomb_off", bomb_on, 0);
        step();
        check("t5_mod_rst_release", mod_rst_n, 1);
        btn_start = 1'b1;
        step();
        sw_en = 1'b1;
        steps(3);
        check("t5_held_stays_idle", phase, 0);
        btn_start = 1'b0;
        step();
        btn_start = 1'b1;
        step();
        btn_start = 1'b0;
        check("t5_fresh_press", phase, 1);

        // 6: reset pulse during SHOW
        run_until(P_SHOW, 10);
        steps(3);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        check("t6_phase", phase, 0);
        check("t6_code", code, 0);
        check("t6_mod_rst_n", mod_rst_n, 1);
        btn_start = 1'b1;
        step();
        check("t6_code_seed", code, 5'b00001);
        btn_start = 1'b0;

        // Random traffic against the model
        for (int i = 0; i < 4000; i++) begin
            rst_n = ($urandom_range(0, 499) != 0);
            if ($urandom_range(0, 149) == 0) sw_en = ~sw_en;
            if ($urandom_range(0, 5) == 0) btn_start = ~btn_start;
            code_ok  = ($urandom_range(0, 59) == 0);
            code_bad = ($urandom_range(0, 59) == 0);
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
